ide_xfer_sequencer: RTL and testbench
=====================================

// Module: ide_xfer_sequencer
// PURPOSE
//  Hardware sequencer for device-to-host sector reads through the IDE register/buffer port.
//  Sits between the AVR bus and the IDE interface register port, and shares that port between the AVR and itself.
//  Per block it arms the ping-pong buffer, starts SD-card fills, programs iopos/iotarget/iocontrol/status and polls the data flag.
//  The AVR only issues start(nblocks, mode) and then sees done or aborted.
// PARAMETERS
//  POLL_GAP   16    cycles between data-flag polls (>=2); the AVR bus is free in between
//  XFER_STAT  8'h58 status written to arm each block (DRDY|DSC|DRQ)
//  END_STAT   8'h50 status written after the last block (DRDY|DSC)
//  ABRT_STAT  8'h51 status written on abort (DRDY|DSC|ERR)
// PORTS
//  clk           in   1   system clock
//  reset_        in   1   asynchronous reset, active low
//  cpu_a         in   11  AVR address
//  cpu_d_in      in   8   AVR write data
//  cpu_cs/oe/we  in   1   AVR strobes
//  cpu_wait      out  1   AVR stall; high while the sequencer owns the port and the AVR has cs asserted
//  ide_a         out  11  port address to the IDE interface
//  ide_d_out     out  8   port write data
//  ide_cs/oe/we  out  1   port strobes
//  ide_d_in      in   8   port read data (combinational, same cycle)
//  start         in   1   pulse; accepted only in IDLE
//  nblocks       in   8   block count sampled with start; 0 means 256
//  mode_dma      in   1   1 = DMA transfer (iocontrol 0x04), 0 = PIO transfer (iocontrol 0x02); sampled with start
//  abort         in   1   pulse; active in any state except IDLE
//  fill_req      out  1   one-cycle pulse asking the SD engine to fill the inactive bank
//  fill_done     in   1   pulse from the SD engine: block landed; latched sticky until consumed
//  busy          out  1   high in every state except IDLE
//  done/aborted  out  1   one-cycle completion pulses
//  blocks_left   out  9   remaining blocks
// BEHAVIOUR
//  Register n is at port address n<<2 with a[10]=0:
//    0 = status + raise IRQ, 2 = iocontrol, 3 = iopos, 4 = status with no IRQ, 5 = iotarget, 6 = flags.
//  Reset values: all outputs 0, state IDLE, fill latch 0, blocks_left 0.
//  Port mux: in owning states the sequencer drives ide_* for exactly one cycle. In all other states ide_* = cpu_*.
//  cpu_wait = cpu_cs & owning state. A stalled AVR access completes the next non-owning cycle.
//  Owning states are every state except IDLE, WAIT_FILL and POLL_GAP.
//  States, in order; each port write takes 1 cycle:
//   IDLE      on start: blocks_left = (nblocks==0 ? 256 : nblocks); go to SETUP
//   SETUP     write reg2 = 8'h46 (SD DMA mode on, SD bank = inactive); pulse fill_req; go to WAIT_FILL
//   WAIT_FILL wait for the fill latch; clear it on exit
//   TOGGLE    write reg2 = 8'h80 (filled bank becomes active); pulse fill_req if blocks_left > 1
//   W_POS     write reg3 = 0
//   W_TGT     write reg5 = 8'hFF (256 words)
//   W_CTL     write reg2 = mode_dma ? 8'h04 : 8'h02
//   W_STAT    write XFER_STAT to reg4 if DMA, to reg0 if PIO
//   POLL_GAP  count POLL_GAP-1 cycles
//   POLL      read reg6. If bit5 (data) is set go to CLR, else back to POLL_GAP
//   CLR       write reg6 = 8'h20; decrement blocks_left
//               blocks_left now 0 -> FINAL; otherwise -> WAIT_FILL
//   FINAL     write reg0 = END_STAT; pulse done; go to IDLE
//  Abort in any non-IDLE state (it preempts that state's action):
//   A_CTL     write reg2 = 8'h00 (DMA and PIO off)
//   A_STAT    write reg0 = ABRT_STAT; pulse aborted; clear the fill latch; go to IDLE
//  Edge cases:
//   - start while busy: ignored.
//   - start and abort together in IDLE: start accepted, abort ignored.
//   - fill_done arriving before WAIT_FILL: latched, so WAIT_FILL exits in 1 cycle.
//   - fill_done outside a transfer: ignored.
//   - blocks_left wraps only by reload; it never decrements below 0.
//   - reset mid-transfer: immediate IDLE with port strobes low. The IDE block resets separately.
// TESTING
//  1. PIO, nblocks=1, fill_done 5 cycles after fill_req, flag set after 300 cycles ->
//     port write sequence 2:46, 2:80, 3:00, 5:FF, 2:02, 0:58, then 6:20, 0:50; done pulses once; blocks_left=0.
//  2. DMA, nblocks=3, fills early ->
//     exactly 3 fill_req pulses; status written via reg4 (not reg0) for every block; 3 toggles of 2:80.
//  3. AVR reads reg0 every cycle during a transfer ->
//     cpu_wait=1 only in owning cycles; every AVR read returns correct data; no sequencer write lost.
//  4. abort during POLL_GAP of block 2 of 4 ->
//     2:00 then 0:51; aborted pulse; busy=0; a later fill_done does not start anything.
//  5. nblocks=0 -> blocks_left=256 and 256 completions before done.
//  6. reset_ low during W_TGT -> all outputs 0 asynchronously; a fresh start after release runs a clean sequence.

Source files
------------

// File: rtl/ide_xfer_sequencer.sv
// Sector-read sequencer: shares the IDE register port with the AVR and walks each
// block through bank toggle, iopos/iotarget/iocontrol/status programming and flag polling.
`timescale 1ns/1ps
module ide_xfer_sequencer #(
  parameter int unsigned POLL_GAP  = 16,
  parameter logic [7:0]  XFER_STAT = 8'h58,
  parameter logic [7:0]  END_STAT  = 8'h50,
  parameter logic [7:0]  ABRT_STAT = 8'h51
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic [10:0] cpu_a,
  input  logic [7:0]  cpu_d_in,
  input  logic        cpu_cs,
  input  logic        cpu_oe,
  input  logic        cpu_we,
  output logic        cpu_wait,
  output logic [10:0] ide_a,
  output logic [7:0]  ide_d_out,
  output logic        ide_cs,
  output logic        ide_oe,
  output logic        ide_we,
  input  logic [7:0]  ide_d_in,
  input  logic        start,
  input  logic [7:0]  nblocks,
  input  logic        mode_dma,
  input  logic        abort,
  output logic        fill_req,
  input  logic        fill_done,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic [8:0]  blocks_left,
  output logic [3:0]  state_dbg
);

  typedef enum logic [3:0] {
    S_IDLE, S_SETUP, S_WAIT_FILL, S_TOGGLE, S_W_POS, S_W_TGT, S_W_CTL,
    S_W_STAT, S_POLL_GAP, S_POLL, S_CLR, S_FINAL, S_A_CTL, S_A_STAT
  } state_t;

  localparam int GW = $clog2(POLL_GAP) + 1;

  state_t         state, state_nx;
  logic           mode_q;
  logic           fill_pend;
  logic [8:0]     left_q;
  logic [GW-1:0]  gap_cnt;
  logic           owning;
  logic           take_abort;
  logic           wr_en, rd_en;
  logic [2:0]     reg_sel;
  logic [7:0]     wr_data;
  logic           fill_clr;
  logic           dec_left;
  logic           unused_d_in;

  // Only the data flag (bit5) of the flags register matters to the sequencer.
  assign unused_d_in = ^{ide_d_in[7:6], ide_d_in[4:0]};

  assign owning      = !(state inside {S_IDLE, S_WAIT_FILL, S_POLL_GAP});
  assign cpu_wait    = cpu_cs & owning;
  assign busy        = (state != S_IDLE);
  assign blocks_left = left_q;
  assign state_dbg   = state;

  always_comb begin
    state_nx   = state;
    take_abort = abort && !(state inside {S_IDLE, S_A_CTL, S_A_STAT});
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    reg_sel    = 3'd0;
    wr_data    = 8'h00;
    fill_req   = 1'b0;
    done       = 1'b0;
    aborted    = 1'b0;
    fill_clr   = 1'b0;
    dec_left   = 1'b0;
    // Abort preempts whatever the current state would have done this cycle.
    if (take_abort) begin
      state_nx = S_A_CTL;
    end else begin
      case (state)
        S_IDLE:      if (start) state_nx = S_SETUP;
        S_SETUP: begin
          wr_en = 1'b1; reg_sel = 3'd2; wr_data = 8'h46;
          fill_req = 1'b1;
          state_nx = S_WAIT_FILL;
        end
        S_WAIT_FILL: if (fill_pend) begin
          fill_clr = 1'b1;
          state_nx = S_TOGGLE;
        end
        S_TOGGLE: begin
          wr_en = 1'b1; reg_sel = 3'd2; wr_data = 8'h80;
          fill_req = (left_q > 9'd1);
          state_nx = S_W_POS;
        end
        S_W_POS: begin
          wr_en = 1'b1; reg_sel = 3'd3; wr_data = 8'h00;
          state_nx = S_W_TGT;
        end
        S_W_TGT: begin
          wr_en = 1'b1; reg_sel = 3'd5; wr_data = 8'hFF;
          state_nx = S_W_CTL;
        end
        S_W_CTL: begin
          wr_en = 1'b1; reg_sel = 3'd2; wr_data = mode_q ? 8'h04 : 8'h02;
          state_nx = S_W_STAT;
        end
        S_W_STAT: begin
          // DMA arms silently via reg4; PIO needs the IRQ from reg0.
          wr_en = 1'b1; reg_sel = mode_q ? 3'd4 : 3'd0; wr_data = XFER_STAT;
          state_nx = S_POLL_GAP;
        end
        S_POLL_GAP:  if (gap_cnt == '0) state_nx = S_POLL;
        S_POLL: begin
          rd_en = 1'b1; reg_sel = 3'd6;
          state_nx = ide_d_in[5] ? S_CLR : S_POLL_GAP;
        end
        S_CLR: begin
          wr_en = 1'b1; reg_sel = 3'd6; wr_data = 8'h20;
          dec_left = 1'b1;
          state_nx = (left_q <= 9'd1) ? S_FINAL : S_WAIT_FILL;
        end
        S_FINAL: begin
          wr_en = 1'b1; reg_sel = 3'd0; wr_data = END_STAT;
          done = 1'b1;
          state_nx = S_IDLE;
        end
        S_A_CTL: begin
          wr_en = 1'b1; reg_sel = 3'd2; wr_data = 8'h00;
          state_nx = S_A_STAT;
        end
        S_A_STAT: begin
          wr_en = 1'b1; reg_sel = 3'd0; wr_data = ABRT_STAT;
          aborted = 1'b1;
          fill_clr = 1'b1;
          state_nx = S_IDLE;
        end
        default:     state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    if (owning) begin
      ide_a     = {6'b000000, reg_sel, 2'b00};
      ide_d_out = wr_data;
      ide_cs    = wr_en | rd_en;
      ide_we    = wr_en;
      ide_oe    = rd_en;
    end else begin
      ide_a     = cpu_a;
      ide_d_out = cpu_d_in;
      ide_cs    = cpu_cs;
      ide_we    = cpu_we;
      ide_oe    = cpu_oe;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state     <= S_IDLE;
      mode_q    <= 1'b0;
      fill_pend <= 1'b0;
      left_q    <= 9'd0;
      gap_cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && start) begin
        left_q <= (nblocks == 8'd0) ? 9'd256 : {1'b0, nblocks};
        mode_q <= mode_dma;
      end else if (dec_left && left_q != 9'd0) begin
        left_q <= left_q - 9'd1;
      end
      // A fill landing on the consuming cycle is kept for the next block.
      if (state == S_IDLE)
        fill_pend <= 1'b0;
      else if (fill_clr)
        fill_pend <= fill_done && (state != S_A_STAT);
      else if (fill_done)
        fill_pend <= 1'b1;
      if (state_nx == S_POLL_GAP && state != S_POLL_GAP)
        gap_cnt <= GW'(POLL_GAP - 2);
      else if (gap_cnt != '0)
        gap_cnt <= gap_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_ide_xfer_sequencer.sv
// Directed bench for ide_xfer_sequencer: logs every port write and compares it
// against hand-built expected write sequences, plus pulse counts and port sharing.
`timescale 1ns/1ps
module tb_ide_xfer_sequencer;

  logic        clk = 1'b0;
  logic        reset_ = 1'b0;
  logic [10:0] cpu_a = '0;
  logic [7:0]  cpu_d_in = '0;
  logic        cpu_cs = 1'b0, cpu_oe = 1'b0, cpu_we = 1'b0;
  logic        cpu_wait;
  logic [10:0] ide_a;
  logic [7:0]  ide_d_out, ide_d_in;
  logic        ide_cs, ide_oe, ide_we;
  logic        start = 1'b0;
  logic [7:0]  nblocks = '0;
  logic        mode_dma = 1'b0, abort = 1'b0;
  logic        fill_req, fill_done, busy, done, aborted;
  logic [8:0]  blocks_left;
  logic [3:0]  state_dbg;

  logic        fill_sched = 1'b0, fill_kick = 1'b0, data_flag = 1'b0;
  int          fill_delay = 5, flag_delay = 300;
  int          fill_timer = 0, flag_timer = 0;
  logic        mon_cpu = 1'b0;
  logic        exp_own;

  logic [18:0] exp_q[$];
  logic [18:0] wr_q[$];
  int fill_req_cnt = 0, done_cnt = 0, ab_cnt = 0, clr_cnt = 0, tog_cnt = 0, stat_cnt = 0;
  int wait_bad = 0, cpu_reads = 0;
  int checks = 0, errors = 0;

  assign fill_done = fill_sched | fill_kick;
  assign ide_d_in  = (ide_a == 11'd24) ? {2'b00, data_flag, 5'b00000} : (8'hA5 ^ ide_a[7:0]);

  ide_xfer_sequencer dut (
    .clk(clk), .reset_(reset_),
    .cpu_a(cpu_a), .cpu_d_in(cpu_d_in), .cpu_cs(cpu_cs), .cpu_oe(cpu_oe), .cpu_we(cpu_we),
    .cpu_wait(cpu_wait),
    .ide_a(ide_a), .ide_d_out(ide_d_out), .ide_cs(ide_cs), .ide_oe(ide_oe), .ide_we(ide_we),
    .ide_d_in(ide_d_in),
    .start(start), .nblocks(nblocks), .mode_dma(mode_dma), .abort(abort),
    .fill_req(fill_req), .fill_done(fill_done),
    .busy(busy), .done(done), .aborted(aborted), .blocks_left(blocks_left),
    .state_dbg(state_dbg)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Port monitor plus SD-engine / IDE-flag responder, sampled mid-cycle.
  always @(negedge clk) begin
    fill_sched = 1'b0;
    if (fill_timer == 1) begin fill_sched = 1'b1; fill_timer = 0; end
    else if (fill_timer > 1) fill_timer = fill_timer - 1;
    if (flag_timer == 1) begin data_flag = 1'b1; flag_timer = 0; end
    else if (flag_timer > 1) flag_timer = flag_timer - 1;
    if (ide_cs && ide_we) begin
      wr_q.push_back({ide_a, ide_d_out});
      if (ide_a == 11'd24 && ide_d_out[5]) begin data_flag = 1'b0; clr_cnt++; end
      if (ide_a == 11'd8 && ide_d_out == 8'h80) tog_cnt++;
      if ((ide_a == 11'd0 || ide_a == 11'd16) && ide_d_out == 8'h58) begin
        stat_cnt++;
        flag_timer = flag_delay;
      end
    end
    if (fill_req) begin fill_req_cnt++; fill_timer = fill_delay; end
    if (done) done_cnt++;
    if (aborted) ab_cnt++;
    if (mon_cpu) begin
      exp_own = !(ide_a == cpu_a && ide_cs == cpu_cs && ide_oe == cpu_oe &&
                  ide_we == cpu_we && ide_d_out == cpu_d_in);
      if (cpu_wait !== (cpu_cs && exp_own)) wait_bad++;
      if (cpu_cs && !cpu_wait) cpu_reads++;
    end
    if (!busy) begin data_flag = 1'b0; flag_timer = 0; fill_timer = 0; end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_w(input int r, input logic [7:0] d);
    logic [10:0] a;
    a = 11'(r * 4);
    exp_q.push_back({a, d});
  endtask

  task automatic push_block(input logic dma);
    push_w(2, 8'h80); push_w(3, 8'h00); push_w(5, 8'hFF);
    push_w(2, dma ? 8'h04 : 8'h02);
    push_w(dma ? 4 : 0, 8'h58);
  endtask

  task automatic start_xfer(input logic [7:0] nb, input logic dma, input logic ab);
    start = 1'b1; nblocks = nb; mode_dma = dma; abort = ab;
    tick(1);
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    for (int i = 0; i < budget && busy; i++) tick(1);
    check({tag, "_finished"}, busy, 1'b0);
  endtask

  task automatic compare_log(input int base, input string tag);
    int n;
    n = wr_q.size() - base;
    check({tag, "_write_count"}, n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n; i++)
      check($sformatf("%s_write%0d", tag, i), wr_q[base + i], exp_q[i]);
  endtask

  initial begin
    int base, d0, f0, a0, c0, t0, s0, w0, r0;

    // Reset
    tick(3);
    check("rst_busy", busy, 1'b0);
    check("rst_blocks_left", blocks_left, 9'd0);
    check("rst_outputs", {fill_req, done, aborted, cpu_wait, ide_cs, ide_we, ide_oe}, 7'd0);
    reset_ = 1'b1;
    tick(2);

    // 1: PIO single block, slow fill and slow flag
    fill_delay = 5; flag_delay = 300;
    exp_q.delete();
    push_w(2, 8'h46); push_block(1'b0); push_w(6, 8'h20); push_w(0, 8'h50);
    base = wr_q.size(); d0 = done_cnt; f0 = fill_req_cnt;
    start_xfer(8'd1, 1'b0, 1'b0);
    check("t1_blocks_left_load", blocks_left, 9'd1);
    wait_idle(2000, "t1");
    compare_log(base, "t1");
    check("t1_done_pulses", done_cnt - d0, 1);
    check("t1_fill_reqs", fill_req_cnt - f0, 1);
    check("t1_blocks_left_end", blocks_left, 9'd0);
    tick(3);

    // 2: DMA three blocks, early fills; start+abort in IDLE, later start while busy
    fill_delay = 1; flag_delay = 4;
    exp_q.delete();
    push_w(2, 8'h46);
    for (int b = 0; b < 3; b++) begin push_block(1'b1); push_w(6, 8'h20); end
    push_w(0, 8'h50);
    base = wr_q.size(); d0 = done_cnt; f0 = fill_req_cnt; t0 = tog_cnt;
    start_xfer(8'd3, 1'b1, 1'b1);
    check("t2_blocks_left_load", blocks_left, 9'd3);
    tick(3);
    start_xfer(8'd7, 1'b0, 1'b0);
    check("t2_start_ignored", blocks_left, 9'd3);
    wait_idle(2000, "t2");
    compare_log(base, "t2");
    check("t2_fill_reqs", fill_req_cnt - f0, 3);
    check("t2_toggles", tog_cnt - t0, 3);
    check("t2_done_pulses", done_cnt - d0, 1);
    tick(3);

    // 3: AVR reading reg0 every cycle during a two-block PIO transfer
    fill_delay = 3; flag_delay = 20;
    exp_q.delete();
    push_w(2, 8'h46);
    for (int b = 0; b < 2; b++) begin push_block(1'b0); push_w(6, 8'h20); end
    push_w(0, 8'h50);
    cpu_a = 11'd0; cpu_cs = 1'b1; cpu_oe = 1'b1; cpu_we = 1'b0;
    base = wr_q.size(); w0 = wait_bad; r0 = cpu_reads; d0 = done_cnt;
    mon_cpu = 1'b1;
    start_xfer(8'd2, 1'b0, 1'b0);
    wait_idle(2000, "t3");
    mon_cpu = 1'b0;
    cpu_cs = 1'b0; cpu_oe = 1'b0;
    compare_log(base, "t3");
    check("t3_wait_mismatch_cycles", wait_bad - w0, 0);
    check("t3_avr_reads_completed", (cpu_reads - r0) > 20, 1'b1);
    check("t3_done_pulses", done_cnt - d0, 1);
    tick(3);

    // 4: abort in the poll gap of block 2 of 4
    fill_delay = 2; flag_delay = 40;
    exp_q.delete();
    push_w(2, 8'h46); push_block(1'b0); push_w(6, 8'h20); push_block(1'b0);
    push_w(2, 8'h00); push_w(0, 8'h51);
    base = wr_q.size(); d0 = done_cnt; a0 = ab_cnt; s0 = stat_cnt;
    start_xfer(8'd4, 1'b0, 1'b0);
    for (int i = 0; i < 2000 && (stat_cnt - s0) < 2; i++) tick(1);
    check("t4_reached_block2", stat_cnt - s0, 2);
    tick(3);
    check("t4_port_free_in_gap", ide_cs, 1'b0);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    wait_idle(20, "t4");
    compare_log(base, "t4");
    check("t4_aborted_pulses", ab_cnt - a0, 1);
    check("t4_no_done", done_cnt - d0, 0);
    base = wr_q.size();
    fill_kick = 1'b1;
    tick(1);
    fill_kick = 1'b0;
    tick(10);
    check("t4_idle_after_fill", busy, 1'b0);
    check("t4_no_writes_after_fill", wr_q.size() - base, 0);

    // 5: nblocks = 0 runs 256 blocks
    fill_delay = 1; flag_delay = 1;
    base = wr_q.size(); d0 = done_cnt; f0 = fill_req_cnt; c0 = clr_cnt; t0 = tog_cnt;
    start_xfer(8'd0, 1'b0, 1'b0);
    check("t5_blocks_left_256", blocks_left, 9'd256);
    wait_idle(20000, "t5");
    check("t5_completions", clr_cnt - c0, 256);
    check("t5_toggles", tog_cnt - t0, 256);
    check("t5_fill_reqs", fill_req_cnt - f0, 256);
    check("t5_done_pulses", done_cnt - d0, 1);
    check("t5_last_write", wr_q[wr_q.size() - 1], {11'd0, 8'h50});
    check("t5_blocks_left_end", blocks_left, 9'd0);
    tick(3);

    // 6: asynchronous reset during W_TGT, then a clean rerun
    fill_delay = 2; flag_delay = 5;
    base = wr_q.size();
    start_xfer(8'd1, 1'b0, 1'b0);
    for (int i = 0; i < 200 && (wr_q.size() - base) < 3; i++) tick(1);
    check("t6_in_w_tgt", {ide_a, ide_d_out, ide_we}, {11'd20, 8'hFF, 1'b1});
    #2;
    reset_ = 1'b0;
    #1;
    check("t6_async_ctrl_zero", {busy, fill_req, done, aborted, cpu_wait, ide_cs, ide_we, ide_oe}, 8'd0);
    check("t6_async_port_zero", {ide_a, ide_d_out}, 19'd0);
    check("t6_async_blocks_left", blocks_left, 9'd0);
    tick(1);
    reset_ = 1'b1;
    tick(2);
    exp_q.delete();
    push_w(2, 8'h46); push_block(1'b0); push_w(6, 8'h20); push_w(0, 8'h50);
    base = wr_q.size(); d0 = done_cnt;
    start_xfer(8'd1, 1'b0, 1'b0);
    wait_idle(2000, "t6");
    compare_log(base, "t6");
    check("t6_done_pulses", done_cnt - d0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
